dtree_channel_sched: RTL and testbench

- Round-robin scheduler that time-shares one dtree classification engine between CHANNELS electrode channels.
- Accepts one sample per channel through a valid/ready handshake and buffers at most one sample per channel.
- Issues at most one sample per cycle to the engine, tracks the channel of each in-flight sample in an in-order tag FIFO, and returns each level/path result tagged with its channel.
- Sits between the per-channel front ends and the shared dtree instance. The engine shares clk/reset with this block.

---
 rtl/dtree_channel_sched.sv | 171 +++++++++++++++++
 tb/tb_dtree_channel_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_channel_sched.sv
// Round-robin scheduler sharing one dtree engine between CHANNELS single-entry channel buffers.
// Define DTREE_SCHED_FIXED_PRIO_EN for fixed priority (lowest full channel wins).
module dtree_channel_sched #(
   parameter int CHANNELS  = 4,
   parameter int IN_WIDTH  = 10,
   parameter int TAG_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [CHANNELS*IN_WIDTH-1:0]  ch_sample,
   input  logic [CHANNELS-1:0]           ch_valid,
   output logic [CHANNELS-1:0]           ch_ready,
   output logic [IN_WIDTH-1:0]           tree_sample,
   output logic                          tree_valid,
   input  logic [1:0]                    tree_level,
   input  logic [1:0]                    tree_path,
   input  logic                          tree_out_valid,
   output logic [$clog2(CHANNELS)-1:0]   res_channel,
   output logic [1:0]                    res_level,
   output logic [1:0]                    res_path,
   output logic                          res_valid,
   output logic                          err_orphan
);
   localparam int CW = $clog2(CHANNELS);
   localparam int AW = $clog2(TAG_DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(TAG_DEPTH);
   localparam logic [CW:0] CH_CNT   = (CW+1)'(CHANNELS);

   logic [CHANNELS-1:0] r_full;
   logic [IN_WIDTH-1:0] r_buf [CHANNELS];
   logic [CW-1:0]       r_ptr;
   logic [CW-1:0]       r_tag [TAG_DEPTH];
   logic [AW-1:0]       r_wptr;
   logic [AW-1:0]       r_rptr;
   logic [AW:0]         r_count;
   logic [IN_WIDTH-1:0] r_tree_sample;
   logic                r_tree_valid;
   logic [CW-1:0]       r_res_channel;
   logic [1:0]          r_res_level;
   logic [1:0]          r_res_path;
   logic                r_res_valid;
   logic                r_err_orphan;

   logic [CW:0]   w_pick;
   logic          w_grant;
   logic [CW-1:0] w_gidx;
   logic          w_tag_full;
   logic          w_tag_empty;
   logic          w_pop;

   // Returns {found, index} of the first full channel at or after ptr, wrapping.
   function automatic logic [CW:0] f_pick(input logic [CHANNELS-1:0] full,
                                          input logic [CW-1:0] ptr);
      logic [CW:0] res;
      logic [CW:0] sum;
      res = '0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (CW+1)'(k);
         sum = (sum >= CH_CNT) ? (sum - CH_CNT) : sum;
         res = full[sum[CW-1:0]] ? {1'b1, sum[CW-1:0]} : res;
      end
      return res;
   endfunction

   // Arbitration and tag FIFO status; a full FIFO blocks the grant even if a pop lands this cycle.
   always_comb begin
      w_tag_full  = (r_count == CNT_FULL);
      w_tag_empty = (r_count == '0);
      w_pop       = tree_out_valid & ~w_tag_empty;
`ifdef DTREE_SCHED_FIXED_PRIO_EN
      w_pick      = f_pick(r_full, '0);
`else
      w_pick      = f_pick(r_full, r_ptr);
`endif
      w_grant     = w_pick[CW] & ~w_tag_full;
      w_gidx      = w_pick[CW-1:0];
   end

   // Channel buffers: a buffer is only loaded while empty and only drained while full.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_full <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            r_buf[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (ch_valid[i] && !r_full[i]) begin
               r_buf[i]  <= ch_sample[i*IN_WIDTH +: IN_WIDTH];
               r_full[i] <= 1'b1;
            end else if (w_grant && (w_gidx == CW'(i))) begin
               r_full[i] <= 1'b0;
            end
         end
      end
   end

   // Issue to the engine and round-robin pointer advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tree_sample <= '0;
         r_tree_valid  <= 1'b0;
         r_ptr         <= '0;
      end else begin
         r_tree_valid <= w_grant;
         if (w_grant) begin
            r_tree_sample <= r_buf[w_gidx];
         end
`ifdef DTREE_SCHED_FIXED_PRIO_EN
         r_ptr <= '0;
`else
         if (w_grant) begin
            r_ptr <= (w_gidx == CW'(CHANNELS - 1)) ? '0 : (w_gidx + CW'(1));
         end
`endif
      end
   end

   // In-order tag FIFO holding the channel of every in-flight sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_grant) begin
            r_tag[r_wptr] <= w_gidx;
            r_wptr        <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_grant, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Result tagging and sticky orphan flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_res_valid   <= 1'b0;
         r_res_channel <= '0;
         r_res_level   <= 2'b00;
         r_res_path    <= 2'b00;
         r_err_orphan  <= 1'b0;
      end else begin
         r_res_valid <= w_pop;
         if (w_pop) begin
            r_res_channel <= r_tag[r_rptr];
            r_res_level   <= tree_level;
            r_res_path    <= tree_path;
         end
         if (tree_out_valid && w_tag_empty) begin
            r_err_orphan <= 1'b1;
         end
      end
   end

   assign ch_ready    = ~r_full;
   assign tree_sample = r_tree_sample;
   assign tree_valid  = r_tree_valid;
   assign res_channel = r_res_channel;
   assign res_level   = r_res_level;
   assign res_path    = r_res_path;
   assign res_valid   = r_res_valid;
   assign err_orphan  = r_err_orphan;

endmodule

// File: tb/tb_dtree_channel_sched.sv
// Self-checking bench for dtree_channel_sched: vector table plus multi-cycle sequences,
// with a 2-cycle engine model and issue/result scoreboards.
module tb_dtree_channel_sched;
   localparam int CH   = 4;
   localparam int IN_W = 10;

   logic              clk;
   logic              reset;
   logic [CH*IN_W-1:0] ch_sample;
   logic [CH-1:0]     ch_valid;
   logic [CH-1:0]     ch_ready;
   logic [IN_W-1:0]   tree_sample;
   logic              tree_valid;
   logic [1:0]        tree_level;
   logic [1:0]        tree_path;
   logic              tree_out_valid;
   logic [1:0]        res_channel;
   logic [1:0]        res_level;
   logic [1:0]        res_path;
   logic              res_valid;
   logic              err_orphan;

   logic              eng_en;
   logic              man_ov;
   logic [1:0]        man_level;
   logic [1:0]        man_path;
   logic              e1_v, e2_v;
   logic [IN_W-1:0]   e1_s, e2_s;

   int n_cmp = 0;
   int n_err = 0;

   logic [IN_W-1:0] iss_q [$];
   logic [5:0]      res_q [$];

   typedef struct {
      int              ch;
      logic [IN_W-1:0] sample;
      logic [1:0]      level;
      logic [1:0]      path;
   } vec_t;
   vec_t tbl [6];

   dtree_channel_sched #(.CHANNELS(4), .IN_WIDTH(10), .TAG_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .ch_sample(ch_sample), .ch_valid(ch_valid),
      .ch_ready(ch_ready), .tree_sample(tree_sample), .tree_valid(tree_valid),
      .tree_level(tree_level), .tree_path(tree_path), .tree_out_valid(tree_out_valid),
      .res_channel(res_channel), .res_level(res_level), .res_path(res_path),
      .res_valid(res_valid), .err_orphan(err_orphan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Engine model: level = sample[2:1], path = sample[1:0], two-cycle latency.
   function automatic logic [1:0] f_lvl(input logic [IN_W-1:0] s);
      return s[2:1];
   endfunction
   function automatic logic [1:0] f_path(input logic [IN_W-1:0] s);
      return s[1:0];
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         e1_v <= 1'b0;
         e2_v <= 1'b0;
         e1_s <= '0;
         e2_s <= '0;
      end else begin
         e1_v <= tree_valid & eng_en;
         e1_s <= tree_sample;
         e2_v <= e1_v;
         e2_s <= e1_s;
      end
   end

   assign tree_out_valid = e2_v | man_ov;
   assign tree_level     = man_ov ? man_level : f_lvl(e2_s);
   assign tree_path      = man_ov ? man_path  : f_path(e2_s);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors, sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (tree_valid) begin
            if (iss_q.size() == 0) chk("issue_unexpected", 32'(iss_q.size()), 32'd1);
            else begin
               chk("sb_issue_sample", 32'(tree_sample), 32'(iss_q[0]));
               iss_q.delete(0);
            end
         end
         if (res_valid) begin
            if (res_q.size() == 0) chk("result_unexpected", 32'(res_q.size()), 32'd1);
            else begin
               chk("sb_res_channel", 32'(res_channel), 32'(res_q[0][5:4]));
               chk("sb_res_level",   32'(res_level),   32'(res_q[0][3:2]));
               chk("sb_res_path",    32'(res_path),    32'(res_q[0][1:0]));
               res_q.delete(0);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset    = 1'b1;
      ch_valid = '0;
      man_ov   = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((iss_q.size() != 0 || res_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_issue_q", 32'(iss_q.size()), 32'd0);
      chk("drain_result_q", 32'(res_q.size()), 32'd0);
   endtask

   task automatic set_ch(input int ch, input logic [IN_W-1:0] s);
      ch_sample[ch*IN_W +: IN_W] = s;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit got;
      reset = 1'b1; ch_valid = '0; ch_sample = '0;
      eng_en = 1'b1; man_ov = 1'b0; man_level = 2'd0; man_path = 2'd0;

      tbl[0] = '{0, 10'h155, 2'd2, 2'd1};
      tbl[1] = '{1, 10'h2AA, 2'd1, 2'd2};
      tbl[2] = '{2, 10'h3FF, 2'd3, 2'd3};
      tbl[3] = '{3, 10'h000, 2'd0, 2'd0};
      tbl[4] = '{3, 10'h00C, 2'd2, 2'd0};
      tbl[5] = '{2, 10'h005, 2'd2, 2'd1};

      // Reset values
      do_reset();
      chk("rst_ch_ready",    32'(ch_ready),    32'hF);
      chk("rst_tree_valid",  32'(tree_valid),  32'd0);
      chk("rst_tree_sample", 32'(tree_sample), 32'd0);
      chk("rst_res_valid",   32'(res_valid),   32'd0);
      chk("rst_res_channel", 32'(res_channel), 32'd0);
      chk("rst_res_level",   32'(res_level),   32'd0);
      chk("rst_res_path",    32'(res_path),    32'd0);
      chk("rst_err_orphan",  32'(err_orphan),  32'd0);

      // Single-channel round trips from the vector table
      for (int r = 0; r < 6; r++) begin
         ch_sample = '0;
         set_ch(tbl[r].ch, tbl[r].sample);
         ch_valid = 4'(1 << tbl[r].ch);
         iss_q.push_back(tbl[r].sample);
         res_q.push_back({2'(tbl[r].ch), tbl[r].level, tbl[r].path});
         tick();
         ch_valid = '0;
         chk("tbl_ready_low",  32'(ch_ready[tbl[r].ch]), 32'd0);
         chk("tbl_no_issue",   32'(tree_valid), 32'd0);
         tick();
         chk("tbl_issue_valid",  32'(tree_valid), 32'd1);
         chk("tbl_issue_sample", 32'(tree_sample), 32'(tbl[r].sample));
         chk("tbl_ready_back",   32'(ch_ready), 32'hF);
         got = 1'b0;
         for (int w = 0; w < 10 && !got; w++) begin
            tick();
            got = res_valid;
         end
         chk("tbl_res_seen", 32'(got), 32'd1);
         chk("tbl_res_channel", 32'(res_channel), 32'(tbl[r].ch));
         chk("tbl_res_level",   32'(res_level),   32'(tbl[r].level));
         chk("tbl_res_path",    32'(res_path),    32'(tbl[r].path));
         tick();
         chk("tbl_res_pulse", 32'(res_valid), 32'd0);
      end
      drain(20);

      // All four channels loaded together: issue order 0,1,2,3
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_ch(i, 10'(i + 1));
         iss_q.push_back(10'(i + 1));
         res_q.push_back({2'(i), f_lvl(10'(i + 1)), f_path(10'(i + 1))});
      end
      ch_valid = 4'hF;
      tick();
      ch_valid = '0;
      chk("all4_ready_low", 32'(ch_ready), 32'h0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("all4_issue_valid",  32'(tree_valid),  32'd1);
         chk("all4_issue_sample", 32'(tree_sample), 32'(k + 1));
         chk("all4_ready",        32'(ch_ready),    32'((1 << (k + 1)) - 1));
      end
      drain(20);

      // Fairness: ch0 and ch2 held valid continuously
      do_reset();
      ch_sample = '0;
      set_ch(0, 10'h0A0);
      set_ch(2, 10'h2B0);
      for (int k = 0; k < 9; k++) begin
         iss_q.push_back((k % 2 == 0) ? 10'h0A0 : 10'h2B0);
         res_q.push_back((k % 2 == 0) ? {2'd0, f_lvl(10'h0A0), f_path(10'h0A0)}
                                      : {2'd2, f_lvl(10'h2B0), f_path(10'h2B0)});
      end
      ch_valid = 4'b0101;
      tick();
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("fair_issue_valid",  32'(tree_valid), 32'd1);
         chk("fair_issue_sample", 32'(tree_sample), (k % 2 == 0) ? 32'h0A0 : 32'h2B0);
      end
      ch_valid = '0;
      tick();
      chk("fair_last_sample", 32'(tree_sample), 32'h0A0);
      tick();
      chk("fair_idle", 32'(tree_valid), 32'd0);
      drain(20);

      // Tag FIFO full: engine withheld after 8 issues
      do_reset();
      eng_en = 1'b0;
      for (int i = 0; i < 4; i++) set_ch(i, 10'(10'h040 + i));
      for (int k = 0; k < 9; k++) iss_q.push_back(10'(10'h040 + (k % 4)));
      ch_valid = 4'hF;
      tick();
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("ff_issue_valid", 32'(tree_valid), 32'd1);
      end
      tick();
      chk("ff_blocked", 32'(tree_valid), 32'd0);
      tick();
      tick();
      chk("ff_still_blocked", 32'(tree_valid), 32'd0);
      chk("ff_bufs_full",     32'(ch_ready),   32'h0);
      man_level = 2'd3; man_path = 2'd2; man_ov = 1'b1;
      res_q.push_back({2'd0, 2'd3, 2'd2});
      tick();
      man_ov = 1'b0;
      chk("ff_pop_res_valid", 32'(res_valid),   32'd1);
      chk("ff_pop_res_ch",    32'(res_channel), 32'd0);
      chk("ff_pop_no_issue",  32'(tree_valid),  32'd0);
      tick();
      chk("ff_one_issue",        32'(tree_valid),  32'd1);
      chk("ff_one_issue_sample", 32'(tree_sample), 32'h040);
      tick();
      chk("ff_full_again", 32'(tree_valid), 32'd0);
      ch_valid = '0;
      chk("ff_queues_used", 32'(iss_q.size() + res_q.size()), 32'd0);
      do_reset();
      eng_en = 1'b1;

      // Orphan result
      man_level = 2'd1; man_path = 2'd1; man_ov = 1'b1;
      tick();
      man_ov = 1'b0;
      chk("orph_flag",     32'(err_orphan), 32'd1);
      chk("orph_no_res",   32'(res_valid),  32'd0);
      tick(); tick(); tick();
      chk("orph_sticky",   32'(err_orphan), 32'd1);
      do_reset();
      chk("orph_cleared",  32'(err_orphan), 32'd0);

      // Reset mid-operation with 3 buffers full and 2 tags in flight
      eng_en = 1'b0;
      ch_sample = '0;
      set_ch(0, 10'h011);
      set_ch(1, 10'h022);
      iss_q.push_back(10'h011);
      iss_q.push_back(10'h022);
      ch_valid = 4'b0011;
      tick();
      ch_valid = '0;
      tick();
      tick();
      chk("mid_second_issue", 32'(tree_sample), 32'h022);
      set_ch(2, 10'h033);
      ch_valid = 4'b0111;
      tick();
      chk("mid_three_full", 32'(ch_ready), 32'b1000);
      reset = 1'b1;
      ch_valid = '0;
      tick();
      reset = 1'b0;
      chk("mid_ready_all",  32'(ch_ready),   32'hF);
      chk("mid_tree_idle",  32'(tree_valid), 32'd0);
      chk("mid_res_idle",   32'(res_valid),  32'd0);
      eng_en = 1'b1;
      set_ch(0, 10'h0A5);
      set_ch(3, 10'h35A);
      iss_q.push_back(10'h0A5);
      iss_q.push_back(10'h35A);
      res_q.push_back({2'd0, f_lvl(10'h0A5), f_path(10'h0A5)});
      res_q.push_back({2'd3, f_lvl(10'h35A), f_path(10'h35A)});
      ch_valid = 4'b1001;
      tick();
      ch_valid = '0;
      tick();
      chk("mid_first_from_ch0", 32'(tree_sample), 32'h0A5);
      tick();
      chk("mid_then_ch3",       32'(tree_sample), 32'h35A);
      drain(20);
      chk("mid_no_orphan", 32'(err_orphan), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
